// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the single-port RAM arbiter: read-owner encoding, RAM
// command stage record and the starvation counter sizing helper.
package ram_port_arbiter_pkg;

    localparam int STARVE_LIMIT_DEF = 3;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } owner_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } ram_cmd_t;

    // Counter must hold STARVE_LIMIT itself and is never narrower than 2 bits.
    function automatic int ctr_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 2) ? 2 : w;
    endfunction

endpackage

// File: rtl/ram_arb_starve_ctr.sv
// Counts data-port grants taken while a fetch request waits and flags when
// the fetch port must be served next.
module ram_arb_starve_ctr
    import ram_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_if_req,
    input  logic i_if_gnt,
    input  logic i_mem_gnt,
    output logic o_starved
);

    localparam int             W     = ctr_width(STARVE_LIMIT);
    localparam logic [W-1:0]   LIMIT = W'(STARVE_LIMIT);

    logic [W-1:0] r_cnt;

    // Consecutive data grants seen by a waiting fetch request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_if_gnt || !i_if_req) begin
            r_cnt <= '0;
        end else if (i_mem_gnt && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_starved = i_if_req && (r_cnt == LIMIT);

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port RAM with
// one-cycle read latency, data-priority and bounded fetch starvation.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_gnt,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    output logic [31:0] ram_addr,
    output logic        ram_we,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wstrb,
    input  logic [31:0] ram_rdata
);

    logic        w_starved;
    owner_e      r_owner;
    owner_e      w_owner_nxt;
    ram_cmd_t    w_cmd;
    logic [31:0] r_ram_addr;
    logic [31:0] r_if_rdata;
    logic [31:0] r_mem_rdata;

    ram_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_if_req  (if_req),
        .i_if_gnt  (if_gnt),
        .i_mem_gnt (mem_gnt),
        .o_starved (w_starved)
    );

    // Grant selection: data port first unless the fetch port has starved.
    always_comb begin
        if_gnt  = 1'b0;
        mem_gnt = 1'b0;
        if (!reset_n) begin
            if_gnt  = 1'b0;
            mem_gnt = 1'b0;
        end else if (if_req && (w_starved || !mem_req)) begin
            if_gnt = 1'b1;
        end else if (mem_req) begin
            mem_gnt = 1'b1;
        end else begin
            if_gnt  = 1'b0;
            mem_gnt = 1'b0;
        end
    end

    // RAM command mux and the owner of the read that returns next cycle.
    always_comb begin
        w_cmd       = '{addr: r_ram_addr, we: 1'b0, wdata: 32'h0000_0000, wstrb: 4'h0};
        w_owner_nxt = OWN_NONE;
        if (!reset_n) begin
            w_cmd.addr = 32'h0000_0000;
        end else if (if_gnt) begin
            w_cmd.addr  = if_addr;
            w_owner_nxt = OWN_IF;
        end else if (mem_gnt) begin
            w_cmd.addr  = mem_addr;
            w_cmd.we    = mem_we;
            w_cmd.wdata = mem_wdata;
            w_cmd.wstrb = mem_wstrb;
            w_owner_nxt = mem_we ? OWN_NONE : OWN_MEM;
        end else begin
            w_cmd.addr = r_ram_addr;
        end
    end

    assign ram_addr  = w_cmd.addr;
    assign ram_we    = w_cmd.we;
    assign ram_wdata = w_cmd.wdata;
    assign ram_wstrb = w_cmd.wstrb;

    // Route returning read data to its owner; the other port keeps its last data.
    always_comb begin
        if_rvalid  = 1'b0;
        mem_rvalid = 1'b0;
        if_rdata   = r_if_rdata;
        mem_rdata  = r_mem_rdata;
        if (!reset_n) begin
            if_rdata  = 32'h0000_0000;
            mem_rdata = 32'h0000_0000;
        end else begin
            case (r_owner)
                OWN_IF: begin
                    if_rvalid = 1'b1;
                    if_rdata  = ram_rdata;
                end
                OWN_MEM: begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = ram_rdata;
                end
                default: begin
                    if_rvalid  = 1'b0;
                    mem_rvalid = 1'b0;
                end
            endcase
        end
    end

    // Owner, held RAM address and last delivered data per port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_owner     <= OWN_NONE;
            r_ram_addr  <= 32'h0000_0000;
            r_if_rdata  <= 32'h0000_0000;
            r_mem_rdata <= 32'h0000_0000;
        end else begin
            r_owner     <= w_owner_nxt;
            r_ram_addr  <= w_cmd.addr;
            r_if_rdata  <= if_rdata;
            r_mem_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench: transaction-level model of the arbiter plus directed
// scenarios with literal expectations and a random traffic phase.
module tb_ram_port_arbiter;

    localparam int STARVE = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_we;
    logic [3:0]  ram_wstrb;

    int errors = 0;
    int checks = 0;

    ram_port_arbiter #(.STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_wstrb(ram_wstrb), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 32'h100) ? 32'hDEAD_BEEF : (32'hC0DE_0000 + 32'(i));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Bench RAM: 1-cycle read latency, byte-strobed writes, contents restored on reset.
    logic [31:0] ram_arr [0:1023];
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 1024; i++) ram_arr[i] <= init_word(i);
            ram_rdata <= 32'h0;
        end else begin
            if (ram_we)
                for (int b = 0; b < 4; b++)
                    if (ram_wstrb[b]) ram_arr[ram_addr[9:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= ram_arr[ram_addr[9:0]];
        end
    end

    // Transaction model: grants from the priority/starvation rules, one pending
    // read with its expected data, a shadow memory and per-port held data.
    initial begin : model
        logic [31:0] sh_mem [0:1023];
        int          m_wait, m_pend;
        logic [31:0] m_pend_data, m_if_hold, m_mem_hold, m_last_addr;
        logic        e_ig, e_mg, e_we, e_irv, e_mrv;
        logic [31:0] e_addr, e_ird, e_mrd;
        for (int i = 0; i < 1024; i++) sh_mem[i] = init_word(i);
        m_wait = 0; m_pend = 0;
        m_pend_data = 32'h0; m_if_hold = 32'h0; m_mem_hold = 32'h0; m_last_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                e_ig = 1'b0; e_mg = 1'b0; e_we = 1'b0; e_addr = 32'h0;
                e_irv = 1'b0; e_mrv = 1'b0; e_ird = 32'h0; e_mrd = 32'h0;
            end else begin
                e_ig   = if_req && (!mem_req || m_wait == STARVE);
                e_mg   = mem_req && !e_ig;
                e_we   = e_mg && mem_we;
                e_addr = e_ig ? if_addr : (e_mg ? mem_addr : m_last_addr);
                e_irv  = (m_pend == 1);
                e_mrv  = (m_pend == 2);
                e_ird  = e_irv ? m_pend_data : m_if_hold;
                e_mrd  = e_mrv ? m_pend_data : m_mem_hold;
            end
            chk("if_gnt", if_gnt, e_ig);
            chk("mem_gnt", mem_gnt, e_mg);
            chk("ram_we", ram_we, e_we);
            chk("ram_addr", ram_addr, e_addr);
            chk("if_rvalid", if_rvalid, e_irv);
            chk("mem_rvalid", mem_rvalid, e_mrv);
            chk("if_rdata", if_rdata, e_ird);
            chk("mem_rdata", mem_rdata, e_mrd);
            if (e_we) begin
                chk("ram_wdata", ram_wdata, mem_wdata);
                chk("ram_wstrb", ram_wstrb, mem_wstrb);
            end
            @(posedge clk);
            if (!reset_n) begin
                for (int i = 0; i < 1024; i++) sh_mem[i] = init_word(i);
                m_wait = 0; m_pend = 0; m_pend_data = 32'h0;
                m_if_hold = 32'h0; m_mem_hold = 32'h0; m_last_addr = 32'h0;
            end else begin
                if (m_pend == 1) m_if_hold = m_pend_data;
                if (m_pend == 2) m_mem_hold = m_pend_data;
                m_pend = e_ig ? 1 : ((e_mg && !mem_we) ? 2 : 0);
                m_pend_data = sh_mem[e_addr[9:0]];
                if (e_we)
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb[b]) sh_mem[mem_addr[9:0]][8*b +: 8] = mem_wdata[8*b +: 8];
                m_last_addr = e_addr;
                if (!if_req || e_ig) m_wait = 0;
                else if (e_mg) m_wait = m_wait + 1;
            end
        end
    end

    initial begin : stim
        logic [11:0] hist;
        logic [3:0]  hist4;
        logic        both, gi, gm;
        reset_n = 1'b0; if_req = 1'b1; if_addr = 32'h8;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h4;
        mem_wdata = 32'hFFFF_FFFF; mem_wstrb = 4'hF;
        @(negedge clk);
        chk("rst_if_gnt", if_gnt, 1'b0);
        chk("rst_mem_gnt", mem_gnt, 1'b0);
        chk("rst_ram_we", ram_we, 1'b0);
        cyc(); cyc();
        reset_n = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        chk("idle_ram_addr", ram_addr, 32'h0);
        cyc();

        // Fetch-only read
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk); chk("f_gnt", if_gnt, 1'b1);
        cyc(); if_req = 1'b0;
        @(negedge clk); chk("f_rvalid", if_rvalid, 1'b1); chk("f_rdata", if_rdata, 32'hDEAD_BEEF);
        cyc();

        // Full write, partial write, read back
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h40; mem_wdata = 32'h1234_5678; mem_wstrb = 4'hF;
        @(negedge clk);
        chk("w_gnt", mem_gnt, 1'b1); chk("w_ram_we", ram_we, 1'b1);
        chk("w_ram_wdata", ram_wdata, 32'h1234_5678); chk("w_ram_addr", ram_addr, 32'h40);
        cyc(); mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        chk("w_no_rvalid", mem_rvalid, 1'b0); chk("w_we_once", ram_we, 1'b0);
        chk("w_addr_held", ram_addr, 32'h40);
        cyc();
        mem_req = 1'b1; mem_we = 1'b1; mem_wdata = 32'hAABB_CCDD; mem_wstrb = 4'h3;
        cyc(); mem_we = 1'b0;
        cyc(); mem_req = 1'b0;
        @(negedge clk); chk("rb_rvalid", mem_rvalid, 1'b1); chk("rb_rdata", mem_rdata, 32'h1234_CCDD);
        cyc();

        // Both request continuously: MEM,MEM,MEM,IF repeating
        hist = 12'h0; both = 1'b0;
        if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if_addr = 32'h200 + 32'(i); mem_addr = 32'h300 + 32'(i);
            @(negedge clk);
            hist = {hist[10:0], if_gnt};
            both = both | (if_gnt & mem_gnt);
            cyc();
        end
        chk("starve_pattern", {20'h0, hist}, 32'h0000_0111);
        chk("starve_no_dual", both, 1'b0);
        if_req = 1'b0; mem_req = 1'b0;
        cyc();

        // Alternating fetch/data reads
        if_req = 1'b1; if_addr = 32'h10;
        cyc(); if_req = 1'b0; mem_req = 1'b1; mem_addr = 32'h20;
        @(negedge clk); chk("alt_if_rv", if_rvalid, 1'b1); chk("alt_if_rd", if_rdata, 32'hC0DE_0010);
        chk("alt_mem_rv0", mem_rvalid, 1'b0);
        cyc(); mem_req = 1'b0;
        @(negedge clk); chk("alt_mem_rv", mem_rvalid, 1'b1); chk("alt_mem_rd", mem_rdata, 32'hC0DE_0020);
        chk("alt_if_rv0", if_rvalid, 1'b0); chk("alt_if_hold", if_rdata, 32'hC0DE_0010);
        cyc();
        for (int i = 0; i < 8; i++) begin
            if_req = i[0] ? 1'b0 : 1'b1; mem_req = i[0] ? 1'b1 : 1'b0;
            if_addr = 32'h30 + 32'(i); mem_addr = 32'h50 + 32'(i);
            cyc();
        end
        if_req = 1'b0; mem_req = 1'b0;
        cyc();

        // Fetch request dropped before grant
        if_req = 1'b1; if_addr = 32'h60; mem_req = 1'b1; mem_addr = 32'h61;
        cyc(); if_req = 1'b0; mem_req = 1'b0;
        @(negedge clk); chk("drop_no_gnt", if_gnt, 1'b0);
        cyc();
        @(negedge clk); chk("drop_no_rvalid", if_rvalid, 1'b0);
        cyc();

        // Reset in the cycle after a fetch read grant
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk); chk("rr_gnt", if_gnt, 1'b1);
        cyc(); if_req = 1'b0; reset_n = 1'b0;
        @(negedge clk);
        chk("rr_rvalid", if_rvalid, 1'b0); chk("rr_if_rdata", if_rdata, 32'h0);
        chk("rr_mem_rdata", mem_rdata, 32'h0); chk("rr_ram_addr", ram_addr, 32'h0);
        cyc(); reset_n = 1'b1;
        hist4 = 4'h0; if_req = 1'b1; mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); hist4 = {hist4[2:0], if_gnt};
            cyc();
        end
        chk("rr_ctr_cleared", hist4, 4'b0001);
        if_req = 1'b0; mem_req = 1'b0;
        cyc();

        // Random traffic, requests held until granted with occasional drops
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); gi = if_gnt; gm = mem_gnt;
            cyc();
            if (!if_req || gi) begin
                if_req = ($urandom_range(0, 2) != 0); if_addr = $urandom;
            end else if ($urandom_range(0, 49) == 0) begin
                if_req = 1'b0;
            end
            if (!mem_req || gm) begin
                mem_req = ($urandom_range(0, 2) != 0); mem_we = $urandom_range(0, 1) == 1;
                mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom_range(0, 15));
            end
        end
        if_req = 1'b0; mem_req = 1'b0;
        cyc(); cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
